// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths, typedefs and constants
package cpu_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 1 << ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard and hazard detect
module reg_scoreboard
   import cpu_pkg::*;
#(
   parameter int ADDR_W = cpu_pkg::ADDR_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 issue_i,
   input  logic [ADDR_W-1:0]    issue_rd_i,
   input  logic                 wb_en_i,
   input  logic [ADDR_W-1:0]    wb_addr_i,
   input  logic [ADDR_W-1:0]    rs_addr_i,
   input  logic [ADDR_W-1:0]    rt_addr_i,
   input  logic                 rs_bypass_i,
   input  logic                 rt_bypass_i,
   output logic                 hazard_o,
   output logic [(1<<ADDR_W)-1:0] pending_o
);

   localparam int N = 1 << ADDR_W;

   logic [N-1:0] pending_q;
   logic [N-1:0] pending_d;
   logic         rs_pend;
   logic         rt_pend;

   // Next pending vector: clear on write-back first, then set so a new producer wins
   always_comb begin
      pending_d = pending_q;
      if (wb_en_i && (wb_addr_i != '0)) begin
         pending_d[wb_addr_i] = 1'b0;
      end
      if (issue_i && (issue_rd_i != '0)) begin
         pending_d[issue_rd_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Pending vector register, cleared asynchronously on reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Source hazards, masked for r0 and for a source satisfied by same-cycle bypass
   always_comb begin
      rs_pend  = pending_q[rs_addr_i] & (rs_addr_i != '0) & ~rs_bypass_i;
      rt_pend  = pending_q[rt_addr_i] & (rt_addr_i != '0) & ~rt_bypass_i;
      hazard_o = rs_pend | rt_pend;
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two read ports, one write port; REGFILE_BYPASS_EN enables write-through bypass
module reg_file
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [ADDR_W-1:0]      RSaddr_i,
   input  logic [ADDR_W-1:0]      RTaddr_i,
   output logic [DATA_W-1:0]      RSdata_o,
   output logic [DATA_W-1:0]      RTdata_o,
   input  logic                   RegWrite_i,
   input  logic [ADDR_W-1:0]      RDaddr_i,
   input  logic [DATA_W-1:0]      RDdata_i,
   input  logic                   issue_i,
   input  logic [ADDR_W-1:0]      issue_rd_i,
   output logic                   hazard_o,
   output logic [(1<<ADDR_W)-1:0] pending_o
);

   localparam int N = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [N];
   logic [DATA_W-1:0] regs_d [N];
   logic              wr_en;
   logic              rs_byp;
   logic              rt_byp;

   assign wr_en = RegWrite_i && (RDaddr_i != '0);

   // Array next state: a single write per cycle; r0 is never written
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[RDaddr_i] = RDdata_i;
      end
   end

   // Array storage, every entry cleared on reset so no unwritten register reads X
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign rs_byp = wr_en && (RDaddr_i == RSaddr_i);
   assign rt_byp = wr_en && (RDaddr_i == RTaddr_i);
`else
   assign rs_byp = 1'b0;
   assign rt_byp = 1'b0;
`endif

   // Read muxes: r0 forced to zero, bypass takes the in-flight write-back data
   always_comb begin
      RSdata_o = regs_q[RSaddr_i];
      RTdata_o = regs_q[RTaddr_i];
      if (rs_byp) begin
         RSdata_o = RDdata_i;
      end
      if (rt_byp) begin
         RTdata_o = RDdata_i;
      end
      if (RSaddr_i == '0) begin
         RSdata_o = '0;
      end
      if (RTaddr_i == '0) begin
         RTdata_o = '0;
      end
   end

   reg_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .issue_i     (issue_i),
      .issue_rd_i  (issue_rd_i),
      .wb_en_i     (RegWrite_i),
      .wb_addr_i   (RDaddr_i),
      .rs_addr_i   (RSaddr_i),
      .rt_addr_i   (RTaddr_i),
      .rs_bypass_i (rs_byp),
      .rt_bypass_i (rt_byp),
      .hazard_o    (hazard_o),
      .pending_o   (pending_o)
   );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - table-driven self-checking bench for reg_file
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i, issue_rd_i;
   logic [31:0] RSdata_o, RTdata_o, RDdata_i;
   logic        RegWrite_i, issue_i, hazard_o;
   logic [31:0] pending_o;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        iss;
      logic [4:0]  ird;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      logic        e_haz;
      logic [31:0] e_pend;
   } vec_t;

   vec_t vecs [$];

   reg_file dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .RSaddr_i   (RSaddr_i),
      .RTaddr_i   (RTaddr_i),
      .RSdata_o   (RSdata_o),
      .RTdata_o   (RTdata_o),
      .RegWrite_i (RegWrite_i),
      .RDaddr_i   (RDaddr_i),
      .RDdata_i   (RDdata_i),
      .issue_i    (issue_i),
      .issue_rd_i (issue_rd_i),
      .hazard_o   (hazard_o),
      .pending_o  (pending_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic we, input logic [4:0] rd,
                      input logic [31:0] wd, input logic iss, input logic [4:0] ird,
                      input logic [31:0] e_rs, input logic [31:0] e_rt, input logic e_haz, input logic [31:0] e_pend);
      vec_t v;
      v.rs = rs; v.rt = rt; v.we = we; v.rd = rd; v.wd = wd; v.iss = iss; v.ird = ird;
      v.e_rs = e_rs; v.e_rt = e_rt; v.e_haz = e_haz; v.e_pend = e_pend;
      vecs.push_back(v);
   endtask

   task automatic idle();
      RegWrite_i = 1'b0; RDaddr_i = '0; RDdata_i = '0; issue_i = 1'b0; issue_rd_i = '0;
   endtask

   initial begin
      rst_i = 1'b1;
      RSaddr_i = '0; RTaddr_i = '0;
      idle();

      //   rs  rt  we rd  wd            iss ird  exp_rs                        exp_rt                        haz             pend
      add(5,  0,  0, 0,  32'h0,        0,  0,   32'h0,                        32'h0,                        0,              32'h0);
      add(7,  7,  1, 7,  32'h12345678, 0,  0,   BYP ? 32'h12345678 : 32'h0,   BYP ? 32'h12345678 : 32'h0,   0,              32'h0);
      add(7,  7,  0, 0,  32'h0,        0,  0,   32'h12345678,                 32'h12345678,                 0,              32'h0);
      add(0,  0,  1, 0,  32'hFFFFFFFF, 1,  0,   32'h0,                        32'h0,                        0,              32'h0);
      add(0,  0,  0, 0,  32'h0,        0,  0,   32'h0,                        32'h0,                        0,              32'h0);
      add(3,  7,  1, 3,  32'hA5A5A5A5, 0,  0,   BYP ? 32'hA5A5A5A5 : 32'h0,   32'h12345678,                 0,              32'h0);
      add(3,  0,  0, 0,  32'h0,        0,  0,   32'hA5A5A5A5,                 32'h0,                        0,              32'h0);
      add(0,  9,  0, 0,  32'h0,        1,  9,   32'h0,                        32'h0,                        0,              32'h0);
      add(0,  9,  0, 0,  32'h0,        0,  0,   32'h0,                        32'h0,                        1,              32'h200);
      add(0,  9,  1, 9,  32'h99,       0,  0,   32'h0,                        BYP ? 32'h99 : 32'h0,         BYP ? 1'b0 : 1'b1, 32'h200);
      add(0,  9,  0, 0,  32'h0,        0,  0,   32'h0,                        32'h99,                       0,              32'h0);
      add(4,  0,  0, 0,  32'h0,        1,  4,   32'h0,                        32'h0,                        0,              32'h0);
      add(4,  0,  1, 4,  32'h44,       1,  4,   BYP ? 32'h44 : 32'h0,         32'h0,                        BYP ? 1'b0 : 1'b1, 32'h10);
      add(4,  0,  0, 0,  32'h0,        0,  0,   32'h44,                       32'h0,                        1,              32'h10);
      add(4,  31, 1, 31, 32'h31313131, 0,  0,   32'h44,                       BYP ? 32'h31313131 : 32'h0,   1,              32'h10);
      add(4,  31, 1, 4,  32'h55,       0,  0,   BYP ? 32'h55 : 32'h44,        32'h31313131,                 BYP ? 1'b0 : 1'b1, 32'h10);
      add(4,  31, 0, 0,  32'h0,        0,  0,   32'h55,                       32'h31313131,                 0,              32'h0);
      add(0,  0,  0, 0,  32'h0,        1,  9,   32'h0,                        32'h0,                        0,              32'h0);
      add(9,  0,  0, 0,  32'h0,        1,  9,   32'h99,                       32'h0,                        1,              32'h200);
      add(9,  0,  0, 0,  32'h0,        0,  0,   32'h99,                       32'h0,                        1,              32'h200);

      // Reset held: outputs quiescent
      repeat (2) @(negedge clk_i);
      #1;
      check("reset_rs", RSdata_o, 32'h0);
      check("reset_haz", {31'h0, hazard_o}, 32'h0);
      check("reset_pend", pending_o, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_i);
         RSaddr_i = vecs[i].rs; RTaddr_i = vecs[i].rt;
         RegWrite_i = vecs[i].we; RDaddr_i = vecs[i].rd; RDdata_i = vecs[i].wd;
         issue_i = vecs[i].iss; issue_rd_i = vecs[i].ird;
         #1;
         check($sformatf("v%0d_rs", i), RSdata_o, vecs[i].e_rs);
         check($sformatf("v%0d_rt", i), RTdata_o, vecs[i].e_rt);
         check($sformatf("v%0d_haz", i), {31'h0, hazard_o}, {31'h0, vecs[i].e_haz});
         check($sformatf("v%0d_pend", i), pending_o, vecs[i].e_pend);
      end

      // Mid-run asynchronous reset after writing r5; r9 is still pending here
      @(negedge clk_i);
      RSaddr_i = 5; RTaddr_i = 7; idle();
      RegWrite_i = 1'b1; RDaddr_i = 5; RDdata_i = 32'hDEADBEEF;
      @(negedge clk_i);
      idle();
      #1;
      check("pre_rst_r5", RSdata_o, 32'hDEADBEEF);
      check("pre_rst_pend", pending_o, 32'h200);
      #1;
      rst_i = 1'b1;
      #1;
      check("async_rst_r5", RSdata_o, 32'h0);
      check("async_rst_r7", RTdata_o, 32'h0);
      check("async_rst_pend", pending_o, 32'h0);
      RSaddr_i = 9;
      #1;
      check("async_rst_haz", {31'h0, hazard_o}, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      RSaddr_i = 5;
      @(negedge clk_i);
      #1;
      check("post_rst_r5", RSdata_o, 32'h0);
      check("post_rst_pend", pending_o, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_file.md
# reg_file

32-entry × 32-bit general-purpose register file that sources the two ALU operands (`data1_i`, `data2_i`) and accepts the write-back result. It sits directly upstream of the ALU in the execute path. It has two combinational read ports and one synchronous write port. A per-register pending-write scoreboard flags read-after-write hazards when a result is not yet written back, for example from a multi-cycle multiply.

## Interface
Parameters:
- `DATA_W`, 32: register and data width.
- `ADDR_W`, 5: register address width; the file has 2^ADDR_W entries.

Ports:
- `clk_i` input 1: clock; all state updates on its rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `RSaddr_i` input ADDR_W: read port A address.
- `RTaddr_i` input ADDR_W: read port B address.
- `RSdata_o` output DATA_W: read port A data; feeds ALU `data1_i`.
- `RTdata_o` output DATA_W: read port B data; feeds ALU `data2_i` path.
- `RegWrite_i` input 1: write enable.
- `RDaddr_i` input ADDR_W: write address.
- `RDdata_i` input DATA_W: write data (ALU `data_o` or memory result).
- `issue_i` input 1: an instruction targeting `issue_rd_i` has issued; mark that register pending.
- `issue_rd_i` input ADDR_W: destination register of the issuing instruction.
- `hazard_o` output 1: a valid source register (RS or RT) is pending.
- `pending_o` output 2^ADDR_W: scoreboard vector, one bit per register (debug/observe).

## Operation
Register 0:
- Hardwired zero: reads return 0, writes are ignored, and it is never marked pending.

Reads:
- Combinational from the array, subject to the bypass rule in Configuration.

Write:
- On the rising edge with `RegWrite_i`=1 and `RDaddr_i`≠0, `regs[RDaddr_i]` ← `RDdata_i`.

Scoreboard, one bit per register, updated on the rising edge:
- **set**: `issue_i`=1 and `issue_rd_i`≠0 sets `pending[issue_rd_i]`.
- **clear**: `RegWrite_i`=1 and `RDaddr_i`≠0 clears `pending[RDaddr_i]`.
- **simultaneous set and clear on the same register**: set wins. The new producer supersedes the retiring one.
- **set on an already-pending register**: the bit stays 1. There is no counting; only one in-flight writer per register is supported.

Hazard output:
- `hazard_o` = (`pending[RSaddr_i]` & `RSaddr_i`≠0) | (`pending[RTaddr_i]` & `RTaddr_i`≠0), masked by the same-cycle write-back where bypass applies (see Configuration).
- Downstream control stalls issue while `hazard_o`=1. `reg_file` itself never stalls.

## Timing
Reset:
- `rst_i` asserted asynchronously clears all registers to 0 and all pending bits to 0.
- While reset is held: `RSdata_o`=`RTdata_o`=0, `hazard_o`=0, `pending_o`=0.
- Reset mid-operation discards any in-flight writes and pending state.

Latencies:
- Read latency: 0 cycles (combinational from address).
- Write latency: data is visible in the array from the cycle after the write edge.
- Scoreboard: `pending_o` and `hazard_o` reflect an issue from the cycle after the issuing edge. A write-back clears the bit at its edge.

Boundaries:
- All-ones address (31) is valid.
- No wrap-around exists.
- No X propagates from an unwritten register, because reset initialises every entry.

## Configuration
Macro `REGFILE_BYPASS_EN`.

Defined:
- Write-through bypass. If `RegWrite_i`=1, `RDaddr_i`≠0 and `RDaddr_i` equals a read address, that read port returns `RDdata_i` in the same cycle.
- That source's pending bit is treated as clear for `hazard_o` in that cycle.

Undefined:
- Reads return the array contents only; a same-cycle write is seen next cycle.
- `hazard_o` uses raw pending bits, so a write-back stalls the consumer one extra cycle.

## Structure
Shared package `cpu_pkg`:
- `DATA_W`, `ADDR_W` and `NUM_REGS`.
- `reg_addr_t` / `word_t` typedefs.
- The `REG_ZERO` constant (0).

Sub-module `reg_scoreboard`:
- Holds the pending vector, the set/clear/priority logic and `hazard_o` generation.
- `reg_file` instantiates it beside the data array and bypass muxes.

## Test plan
- **Reset values**: assert `rst_i` mid-run after writing 0xDEADBEEF to r5 → `RSdata_o` reading r5 = 0; `pending_o`=0; `hazard_o`=0.
- **Basic write/read**: write 0x12345678 to r7 → next cycle, RS=r7 and RT=r7 both return 0x12345678.
- **Register 0**: write 0xFFFFFFFF to r0 and issue r0 → reads of r0 = 0; `pending_o[0]`=0; `hazard_o`=0.
- **Bypass**: same-cycle write of 0xA5A5A5A5 to r3 with RS=r3.
  - With `REGFILE_BYPASS_EN`: `RSdata_o`=0xA5A5A5A5 that cycle.
  - Without it: old value that cycle, new value the next cycle.
- **Scoreboard**: issue r9; next cycle RT=r9 → `hazard_o`=1; write-back r9 → `hazard_o`=0 (same cycle with bypass, next cycle without).
- **Set-wins collision**: r4 pending; in one cycle, write-back r4 and issue r4 → `pending_o[4]` stays 1.
